adc_max11331_spi_ctrl: RTL

SPI sequencer for the MAX11331 12-bit, 16-channel SAR ADC. It sits directly upstream of the ADC_max11331_AXI register bank. On each start it runs one manual-mode scan of channels 0..N_CH-1 and delivers each 12-bit result, tagged with its channel number, over a valid/ready stream that the register bank consumes. It handles the ADC's one-frame result pipeline, SCLK generation and chip-select timing.

---
 rtl/adc_max11331_spi_ctrl.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/adc_max11331_spi_ctrl.sv
// Manual-mode scan sequencer for the MAX11331 ADC: SPI framing plus a valid/ready result stream.
// Define ADC_MAX11331_CHID_CHECK_EN to take sample_ch from the returned channel ID and flag mismatches.
module adc_max11331_spi_ctrl #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned N_CH    = 4
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic        start,
  output logic        busy,
  output logic        scan_done,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic [11:0] sample_data,
  output logic [3:0]  sample_ch,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        ch_error
);

  typedef enum logic [2:0] {
    StIdle, StCsSetup, StShift, StCsHold, StQuiet, StOutput, StDone
  } state_e;

  localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);
  localparam logic [4:0] KLast   = 5'(N_CH);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  half_q, half_d;
  logic [4:0]  k_q, k_d;
  logic [15:0] tx_q, tx_d, rx_q, rx_d;
  logic        cs_n_q, cs_n_d, sclk_q, sclk_d;
  logic        valid_q, valid_d, err_q, err_d;
  logic [11:0] data_q, data_d;
  logic [3:0]  ch_q, ch_d;
  logic        div_last;
  logic [3:0]  ch_exp;

  // The last frame of a scan is a dummy that only flushes the ADC result pipeline.
  function automatic logic [15:0] cmd_word(input logic [4:0] k);
    logic [3:0] chsel;
    chsel = (k == KLast) ? 4'd0 : k[3:0];
    return {1'b0, 4'b0001, chsel, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0};
  endfunction

  assign div_last = (div_q == DivLast);
  assign ch_exp   = 4'(k_q - 5'd1);

  always_comb begin
    state_d = state_q;
    div_d   = div_last ? 8'd0 : div_q + 8'd1;
    half_d  = half_q;
    k_d     = k_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    valid_d = valid_q;
    err_d   = err_q;
    data_d  = data_q;
    ch_d    = ch_q;
    unique case (state_q)
      StIdle: begin
        div_d = 8'd0;
        if (start) begin
          state_d = StCsSetup;
          k_d     = 5'd0;
          cs_n_d  = 1'b0;
          tx_d    = cmd_word(5'd0);
          err_d   = 1'b0;
        end
      end
      StCsSetup: begin
        if (div_last) begin
          state_d = StShift;
          sclk_d  = 1'b0;
          half_d  = 5'd0;
        end
      end
      StShift: begin
        // Odd half-periods are SCLK high; capture MISO in the first cycle of each.
        if (half_q[0] && div_q == 8'd0) begin
          rx_d = {rx_q[14:0], spi_miso};
        end
        if (div_last) begin
          if (half_q == 5'd31) begin
            state_d = StCsHold;
            sclk_d  = 1'b1;
          end else begin
            half_d = half_q + 5'd1;
            sclk_d = ~sclk_q;
            if (half_q[0]) begin
              tx_d = {tx_q[14:0], 1'b0};
            end
          end
        end
      end
      StCsHold: begin
        if (div_last) begin
          state_d = StQuiet;
          cs_n_d  = 1'b1;
        end
      end
      StQuiet: begin
        if (div_last) begin
          if (k_q == 5'd0) begin
            state_d = StCsSetup;
            k_d     = 5'd1;
            cs_n_d  = 1'b0;
            tx_d    = cmd_word(5'd1);
          end else begin
            state_d = StOutput;
            valid_d = 1'b1;
            data_d  = rx_q[11:0];
`ifdef ADC_MAX11331_CHID_CHECK_EN
            ch_d = rx_q[15:12];
            if (rx_q[15:12] != ch_exp) begin
              err_d = 1'b1;
            end
`else
            ch_d = ch_exp;
`endif
          end
        end
      end
      StOutput: begin
        div_d = 8'd0;
        if (valid_q && sample_ready) begin
          valid_d = 1'b0;
          if (k_q == KLast) begin
            state_d = StDone;
          end else begin
            state_d = StCsSetup;
            k_d     = k_q + 5'd1;
            cs_n_d  = 1'b0;
            tx_d    = cmd_word(k_q + 5'd1);
          end
        end
      end
      StDone: begin
        div_d   = 8'd0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= StIdle;
      div_q   <= 8'd0;
      half_q  <= 5'd0;
      k_q     <= 5'd0;
      tx_q    <= 16'd0;
      rx_q    <= 16'd0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= 12'd0;
      ch_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      half_q  <= half_d;
      k_q     <= k_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
    end
  end

`ifndef ADC_MAX11331_CHID_CHECK_EN
  logic unused_chid;
  assign unused_chid = ^rx_q[15:12];
`endif

  assign busy         = (state_q != StIdle) && (state_q != StDone);
  assign scan_done    = (state_q == StDone);
  assign spi_cs_n     = cs_n_q;
  assign spi_sclk     = sclk_q;
  assign spi_mosi     = tx_q[15];
  assign sample_data  = data_q;
  assign sample_ch    = ch_q;
  assign sample_valid = valid_q;
  assign ch_error     = err_q;

endmodule
